// File: rtl/paillier_stream_host_pkg.sv
// Shared opcodes, FSM encoding and default geometry for the Paillier host stream adapter.
package paillier_stream_host_pkg;

  localparam int unsigned DEF_RSA_WIDTH   = 4096;
  localparam int unsigned DEF_DATA_WIDTH  = 128;
  localparam int unsigned DEF_DATA_NUMBER = 32;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] ENCRY    = 4'b0001;
  localparam logic [OP_W-1:0] DECRY    = 4'b0010;
  localparam logic [OP_W-1:0] HOMO_ADD = 4'b0100;
  localparam logic [OP_W-1:0] HOMO_MUL = 4'b1000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEND = 3'd1,
    WAIT = 3'd2,
    RECV = 3'd3,
    DONE = 3'd4
  } host_state_t;

  // Only the four one-hot codes are accepted; zero and multi-hot codes are rejected.
  function automatic logic op_legal(input logic [OP_W-1:0] code);
    return (code == ENCRY) || (code == DECRY) || (code == HOMO_ADD) || (code == HOMO_MUL);
  endfunction

endpackage

// File: rtl/paillier_beat_serializer.sv
// Wide-to-narrow serializer: two parallel shift registers emitted LSW-first, one beat per cycle.
module paillier_beat_serializer #(
  parameter int unsigned WIDE   = 4096,
  parameter int unsigned NARROW = 128,
  parameter int unsigned COUNT  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WIDE-1:0]   wide_a,
  input  logic [WIDE-1:0]   wide_b,
  output logic [NARROW-1:0] lane_1,
  output logic [NARROW-1:0] lane_2,
  output logic              valid,
  output logic              last_c
);

  localparam int unsigned CNT_W = $clog2(COUNT + 1);

  logic [WIDE-1:0]  sreg_a;
  logic [WIDE-1:0]  sreg_b;
  logic [CNT_W-1:0] cnt;

  assign last_c = valid && (cnt == CNT_W'(COUNT - 1));

  // Lanes come straight off the register LSBs; after the final shift both registers hold zero.
  assign lane_1 = sreg_a[NARROW-1:0];
  assign lane_2 = sreg_b[NARROW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_a <= '0;
      sreg_b <= '0;
      cnt    <= '0;
      valid  <= 1'b0;
    end else if (load) begin
      sreg_a <= wide_a;
      sreg_b <= wide_b;
      cnt    <= '0;
      valid  <= 1'b1;
    end else if (valid) begin
      sreg_a <= sreg_a >> NARROW;
      sreg_b <= sreg_b >> NARROW;
      cnt    <= cnt + CNT_W'(1);
      if (last_c) valid <= 1'b0;
    end
  end

endmodule

// File: rtl/paillier_stream_host.sv
// Host side of the Paillier block port: serializes an operand pair, reassembles the streamed result.
// Optional watchdog on the result phase is enabled by defining PAILLIER_HOST_TIMEOUT_EN.
module paillier_stream_host
  import paillier_stream_host_pkg::*;
#(
  parameter int unsigned RSA_WIDTH   = DEF_RSA_WIDTH,
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned DATA_NUMBER = DEF_DATA_NUMBER
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [OP_W-1:0]       op,
  input  logic [RSA_WIDTH-1:0]  operand_a,
  input  logic [RSA_WIDTH-1:0]  operand_b,
  output logic                  busy,
  output logic                  beat_valid,
  output logic [DATA_WIDTH-1:0] number_1,
  output logic [DATA_WIDTH-1:0] number_2,
  output logic [OP_W-1:0]       state,
  input  logic                  res_valid,
  input  logic [DATA_WIDTH-1:0] res_data,
  input  logic                  res_done,
  output logic [RSA_WIDTH-1:0]  result,
  output logic                  result_valid,
  output logic                  err
);

  localparam int unsigned IDX_W = $clog2(DATA_NUMBER + 1);

  if (RSA_WIDTH != DATA_WIDTH * DATA_NUMBER) begin : g_width_check
    $error("paillier_stream_host: RSA_WIDTH must equal DATA_WIDTH*DATA_NUMBER");
  end

  host_state_t          fsm;
  host_state_t          fsm_d;
  logic [OP_W-1:0]      state_d;
  logic                 busy_d;
  logic                 err_d;
  logic                 result_valid_d;
  logic [RSA_WIDTH-1:0] result_d;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     idx_d;
  logic                 load_c;
  logic                 send_last_c;
  logic                 timeout_c;
  logic [RSA_WIDTH-1:0] load_b_c;

  // Decryption has no second operand; its lane carries zeros.
  assign load_b_c = (op == DECRY) ? '0 : operand_b;

  paillier_beat_serializer #(
    .WIDE   (RSA_WIDTH),
    .NARROW (DATA_WIDTH),
    .COUNT  (DATA_NUMBER)
  ) u_serializer (
    .clk    (clk),
    .rst    (rst),
    .load   (load_c),
    .wide_a (operand_a),
    .wide_b (load_b_c),
    .lane_1 (number_1),
    .lane_2 (number_2),
    .valid  (beat_valid),
    .last_c (send_last_c)
  );

`ifdef PAILLIER_HOST_TIMEOUT_EN
  localparam int unsigned TIMEOUT_CYCLES = 1_000_000;

  logic [31:0] watchdog;

  // Counts idle cycles while waiting on the block; any result beat restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      watchdog <= '0;
    end else if ((fsm == WAIT || fsm == RECV) && !res_valid) begin
      watchdog <= watchdog + 32'd1;
    end else begin
      watchdog <= '0;
    end
  end

  assign timeout_c = (fsm == WAIT || fsm == RECV) && !res_valid &&
                     (watchdog == 32'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_c = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm          <= IDLE;
      state        <= '0;
      busy         <= 1'b0;
      err          <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      idx          <= '0;
    end else begin
      fsm          <= fsm_d;
      state        <= state_d;
      busy         <= busy_d;
      err          <= err_d;
      result_valid <= result_valid_d;
      result       <= result_d;
      idx          <= idx_d;
    end
  end

  always_comb begin
    fsm_d    = fsm;
    state_d  = state;
    err_d    = 1'b0;
    result_d = result;
    idx_d    = idx;
    load_c   = 1'b0;

    unique case (fsm)
      IDLE: begin
        if (res_valid) err_d = 1'b1;
        if (start) begin
          if (op_legal(op)) begin
            load_c   = 1'b1;
            state_d  = op;
            result_d = '0;
            idx_d    = '0;
            fsm_d    = SEND;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      SEND: begin
        if (res_valid) err_d = 1'b1;
        if (send_last_c) fsm_d = WAIT;
      end

      // The final beat wins over a coincident res_done; an earlier res_done truncates the result.
      WAIT, RECV: begin
        if (res_valid) begin
          result_d[32'(idx) * DATA_WIDTH +: DATA_WIDTH] = res_data;
          idx_d = idx + IDX_W'(1);
          fsm_d = RECV;
        end
        if (res_valid && idx == IDX_W'(DATA_NUMBER - 1)) begin
          fsm_d = DONE;
        end else if (res_done) begin
          err_d = 1'b1;
          fsm_d = DONE;
        end else if (timeout_c) begin
          err_d    = 1'b1;
          result_d = '0;
          fsm_d    = DONE;
        end
      end

      DONE: begin
        if (res_valid) err_d = 1'b1;
        state_d = '0;
        fsm_d   = IDLE;
      end

      default: fsm_d = IDLE;
    endcase

    busy_d         = (fsm_d != IDLE);
    result_valid_d = (fsm_d == DONE) && (fsm != DONE);
  end

endmodule

// File: doc/paillier_stream_host.md
Name: paillier_stream_host

Overview:
- Host-side counterpart of the Paillier block port, on the opposite end of that port.
- Takes one wide operand pair plus an opcode and serializes them LSW-first into DATA_NUMBER narrow beats on number_1/number_2. The opcode is held on state throughout.
- Collects the DATA_NUMBER narrow result beats the block streams back, reassembles them into one RSA_WIDTH word and pulses result_valid.
- Sits between the test/host controller and the Paillier block wrapper.

Parameters:
- RSA_WIDTH, 4096, width of the wide operands and result.
- DATA_WIDTH, 128, width of one beat.
- DATA_NUMBER, 32, beats per operand; RSA_WIDTH == DATA_WIDTH*DATA_NUMBER is required, checked by an elaboration-time assertion.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  4  one-hot: 0001 encry, 0010 decry, 0100 homo_add, 1000 homo_mul.
- operand_a  in  RSA_WIDTH  m (encry, homo_mul), c (decry), c1 (homo_add).
- operand_b  in  RSA_WIDTH  r (encry), c (homo_mul), c2 (homo_add); ignored for decry.
- busy  out  1  high in every state except IDLE.
- beat_valid  out  1  number_1/number_2 carry a beat this cycle.
- number_1  out  DATA_WIDTH  beat of operand_a.
- number_2  out  DATA_WIDTH  beat of operand_b (0 for decry).
- state  out  4  latched op; stable from the first beat until the cycle after result_valid.
- res_valid  in  1  one result beat on res_data this cycle.
- res_data  in  DATA_WIDTH  result beat, LSW first.
- res_done  in  1  block end-of-result pulse.
- result  out  RSA_WIDTH  reassembled result.
- result_valid  out  1  one-cycle pulse; result is valid and held until the next start.
- err  out  1  one-cycle pulse on a protocol error.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, counters 0. Reset asserted mid-operation aborts immediately; no result_valid is produced.
- IDLE:
  - start=1 with a legal one-hot op: latch op into state, load operand_a/operand_b into shift registers (operand_b forced to 0 for decry), clear result, go to SEND.
  - start=1 with an illegal op (zero, multi-hot or other code): err pulse next cycle, stay IDLE, state stays 0.
- SEND: beat_valid=1 for exactly DATA_NUMBER consecutive cycles.
  - Beat k carries bits [DATA_WIDTH*k +: DATA_WIDTH]; the shift registers shift right by DATA_WIDTH each beat.
  - start at edge t gives beat 0 at cycle t+1 and the last beat at t+DATA_NUMBER.
  - Beat counter is $clog2(DATA_NUMBER+1) bits; on reaching DATA_NUMBER go to WAIT. beat_valid and number_* drop to 0 in WAIT.
- WAIT: hold state. The first res_valid moves to RECV and captures that beat as beat 0.
- RECV: each res_valid writes res_data into result slice j and increments j.
  - After beat DATA_NUMBER-1 go to DONE.
  - res_done before all beats have arrived: err pulse, go to DONE with a partial result.
- DONE: one cycle.
  - result_valid=1, then IDLE.
  - state clears to 0 on entry to IDLE.
  - Any res_valid arriving in DONE or IDLE is dropped and pulses err.
- Simultaneous events:
  - start while busy is ignored; no err.
  - res_valid during SEND is treated as a protocol error (err pulse) and the beat is dropped.
  - res_done coincident with the final beat is legal: no err.
- Minimum total latency is 2*DATA_NUMBER+2 cycles from start to result_valid, with zero block compute time.

Optional Feature:
- PAILLIER_HOST_TIMEOUT_EN.
- Defined:
  - A 32-bit watchdog counts cycles spent in WAIT/RECV; limit set by localparam TIMEOUT_CYCLES = 1_000_000.
  - On expiry: err pulse, result_valid pulse with result forced to all-zero, return to IDLE.
  - The counter clears on every res_valid.
- Undefined: no watchdog; the FSM waits indefinitely in WAIT/RECV.

Decomposition:
- Shared package holds:
  - op code localparams (ENCRY, DECRY, HOMO_ADD, HOMO_MUL)
  - FSM state encoding (IDLE, SEND, WAIT, RECV, DONE)
  - the default RSA_WIDTH/DATA_WIDTH/DATA_NUMBER
- One natural sub-module, paillier_beat_serializer: a parameterized wide-to-narrow shift register plus beat counter, instantiated once and driving both lanes.
- Reassembly stays inline.

Test Plan:
- Encry, operand_a=42, operand_b=23 -> beat 0 has number_1=42, number_2=23; beats 1..31 are 0; state=0001 for all 32 beats. Respond with beat 0 = 0x1234, rest 0 -> result=0x1234, result_valid one pulse.
- Decry, operand_a = {32 beats, beat k = k+1}, operand_b = all-ones -> number_1 beat k = k+1; number_2 = 0 on every beat.
- Homo_add with result beats delayed 5 cycles between each -> result slice k = k-th beat; result_valid exactly 1 cycle after the last beat.
- op=0011 with start -> err pulse, busy stays 0, beat_valid never rises.
- res_done after 10 of 32 beats -> err pulse, result_valid pulse, slices 10..31 = 0.
- Reset asserted during beat 15 of SEND -> all outputs 0 next cycle. A following encry with m=1, r=1 completes normally.
